// File: rtl/sort_net_pkg.sv
// sort_net_pkg: shared helpers for the pipelined bitonic sorter.
//   idx_w       - bits needed to hold a lane index
//   layer_count - number of comparator layers for an N-lane bitonic network
//   layer_k/j   - (block size k, compare distance j) of layer s
//   pair_lane   - partner lane of a lane in layer s
//   lane_rev    - 1 when the comparator on this lane runs against the global direction
package sort_net_pkg;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int layer_count(input int n);
        int lg;
        lg = $clog2(n);
        return lg * (lg + 1) / 2;
    endfunction

    // Layers are enumerated k = 2, 4 .. n, and for each k, j = k/2 down to 1.
    function automatic int layer_k(input int n, input int s);
        int cnt;
        int res;
        cnt = 0;
        res = 0;
        for (int k = 2; k <= n; k = k * 2) begin
            for (int j = k / 2; j >= 1; j = j / 2) begin
                if (cnt == s) res = k;
                cnt++;
            end
        end
        return res;
    endfunction

    function automatic int layer_j(input int n, input int s);
        int cnt;
        int res;
        cnt = 0;
        res = 0;
        for (int k = 2; k <= n; k = k * 2) begin
            for (int j = k / 2; j >= 1; j = j / 2) begin
                if (cnt == s) res = j;
                cnt++;
            end
        end
        return res;
    endfunction

    function automatic int pair_lane(input int n, input int s, input int lane);
        return lane ^ layer_j(n, s);
    endfunction

    // Sub-sequences whose block bit k is set are sorted the opposite way,
    // which is what makes the merged halves bitonic.
    function automatic logic lane_rev(input int n, input int s, input int lane);
        return (lane & layer_k(n, s)) != 0;
    endfunction

endpackage

// File: rtl/sort_net_pipe_cas_cell.sv
// cas_cell: one compare-and-swap element.
//   dir        1 = descending (a ends up >= b), 0 = ascending (a ends up <= b)
//   a, b       element on the lower / upper lane
//   lo, hi     result for the lower / upper lane
//   a_tag, b_tag, lo_tag, hi_tag  lane tags, present only with SORT_TAG_EN
// Swaps only when the pair is strictly out of order, so equal values keep
// their lanes (and tags).
module cas_cell #(
    parameter int WIDTH = 10
`ifdef SORT_TAG_EN
    , parameter int TAG_W = 2
`endif
) (
    input  logic             dir,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SORT_TAG_EN
    input  logic [TAG_W-1:0] a_tag,
    input  logic [TAG_W-1:0] b_tag,
    output logic [TAG_W-1:0] lo_tag,
    output logic [TAG_W-1:0] hi_tag,
`endif
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    logic [WIDTH-1:0] minu;
    logic [WIDTH-1:0] subt;
    logic [WIDTH-1:0] diff_unused;
    logic             borrow;

    // One subtractor: the operand order is picked so that a borrow means
    // "this pair is out of order for the requested direction".
    assign minu = dir ? a : b;
    assign subt = dir ? b : a;
    assign {borrow, diff_unused} = {1'b0, minu} - {1'b0, subt};

    assign lo = borrow ? b : a;
    assign hi = borrow ? a : b;
`ifdef SORT_TAG_EN
    assign lo_tag = borrow ? b_tag : a_tag;
    assign hi_tag = borrow ? a_tag : b_tag;
`endif

endmodule

// File: rtl/sort_net_pipe.sv
// sort_net_pipe: fully pipelined bitonic sorter, one register per comparator layer.
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   input handshake; in_data (lane i at [i*WIDTH +: WIDTH]), in_desc
//   out_valid/out_ready output handshake; out_data sorted, same lane packing
//   out_tag             original lane index per output lane (only with SORT_TAG_EN)
//   busy                any stage holds a valid vector
// Optional feature macro: SORT_TAG_EN.
// The whole pipe stalls as one unit whenever the output is offered but not
// taken, so in_ready is a pure function of the last stage.
module sort_net_pipe
    import sort_net_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int N     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N*WIDTH-1:0]        in_data,
    input  logic                      in_desc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N*WIDTH-1:0]        out_data,
`ifdef SORT_TAG_EN
    output logic [N*idx_w(N)-1:0]     out_tag,
`endif
    output logic                      busy
);

    localparam int S = layer_count(N);
`ifdef SORT_TAG_EN
    localparam int IW = idx_w(N);
`endif

    logic [WIDTH-1:0] lay_in  [S][N];
    logic [WIDTH-1:0] lay_out [S][N];
    logic [WIDTH-1:0] reg_d   [S][N];
    logic [S-1:0]     reg_v;
    logic [S-1:0]     lay_dir;
    logic             adv;
`ifdef SORT_TAG_EN
    logic [IW-1:0]    tag_in  [S][N];
    logic [IW-1:0]    tag_out [S][N];
    logic [IW-1:0]    reg_t   [S][N];
`endif

    assign in_ready  = !(out_valid && !out_ready);
    assign adv       = in_ready;
    assign out_valid = reg_v[S-1];
    assign busy      = |reg_v;

    // Layer s reads register stage s-1 (layer 0 reads the input port).
    for (genvar i = 0; i < N; i++) begin : g_src
        assign lay_in[0][i] = in_data[i*WIDTH +: WIDTH];
`ifdef SORT_TAG_EN
        assign tag_in[0][i] = IW'(i);
`endif
        for (genvar s = 1; s < S; s++) begin : g_stage
            assign lay_in[s][i] = reg_d[s-1][i];
`ifdef SORT_TAG_EN
            assign tag_in[s][i] = reg_t[s-1][i];
`endif
        end
        assign out_data[i*WIDTH +: WIDTH] = reg_d[S-1][i];
`ifdef SORT_TAG_EN
        assign out_tag[i*IW +: IW] = reg_t[S-1][i];
`endif
    end

    // The last stage's direction is never consumed, so only S-1 direction
    // bits are registered behind the input.
    if (S > 1) begin : g_dir
        logic [S-2:0] dir_q;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                dir_q <= '0;
            end else if (adv) begin
                dir_q[0] <= in_desc;
                for (int s = 1; s < S - 1; s++) dir_q[s] <= dir_q[s-1];
            end
        end
        assign lay_dir = {dir_q, in_desc};
    end else begin : g_dir1
        assign lay_dir = in_desc;
    end

    for (genvar s = 0; s < S; s++) begin : g_layer
        for (genvar i = 0; i < N; i++) begin : g_lane
            if (pair_lane(N, s, i) > i) begin : g_cas
                localparam int P = pair_lane(N, s, i);
                cas_cell #(
                    .WIDTH (WIDTH)
`ifdef SORT_TAG_EN
                    , .TAG_W (IW)
`endif
                ) u_cas (
                    .dir    (lay_dir[s] ^ lane_rev(N, s, i)),
                    .a      (lay_in[s][i]),
                    .b      (lay_in[s][P]),
`ifdef SORT_TAG_EN
                    .a_tag  (tag_in[s][i]),
                    .b_tag  (tag_in[s][P]),
                    .lo_tag (tag_out[s][i]),
                    .hi_tag (tag_out[s][P]),
`endif
                    .lo     (lay_out[s][i]),
                    .hi     (lay_out[s][P])
                );
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_v <= '0;
            for (int s = 0; s < S; s++) begin
                for (int i = 0; i < N; i++) begin
                    reg_d[s][i] <= '0;
`ifdef SORT_TAG_EN
                    reg_t[s][i] <= '0;
`endif
                end
            end
        end else if (adv) begin
            reg_v[0] <= in_valid;
            for (int s = 1; s < S; s++) reg_v[s] <= reg_v[s-1];
            for (int s = 0; s < S; s++) begin
                for (int i = 0; i < N; i++) begin
                    reg_d[s][i] <= lay_out[s][i];
`ifdef SORT_TAG_EN
                    reg_t[s][i] <= tag_out[s][i];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_sort_net_pipe.sv
module tb_sort_net_pipe;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    // N=4, WIDTH=10 instance
    logic         a_iv, a_ir, a_desc, a_ov, a_ordy, a_busy;
    logic [39:0]  a_id, a_od;
    // N=16, WIDTH=16 instance
    logic         b_iv, b_ir, b_desc, b_ov, b_ordy, b_busy;
    logic [255:0] b_id, b_od;
`ifdef SORT_TAG_EN
    logic [7:0]   a_ot;
    logic [63:0]  b_ot;
`endif

    sort_net_pipe #(.WIDTH(10), .N(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
        .in_desc(a_desc), .out_valid(a_ov), .out_ready(a_ordy), .out_data(a_od),
`ifdef SORT_TAG_EN
        .out_tag(a_ot),
`endif
        .busy(a_busy));

    sort_net_pipe #(.WIDTH(16), .N(16)) u_s16 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
        .in_desc(b_desc), .out_valid(b_ov), .out_ready(b_ordy), .out_data(b_od),
`ifdef SORT_TAG_EN
        .out_tag(b_ot),
`endif
        .busy(b_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic longint unsigned lane_of(input logic [255:0] d, input int i, input int w);
        logic [255:0] m;
        m = (256'd1 << w) - 256'd1;
        return 64'((d >> (i * w)) & m);
    endfunction

    // Reference: plain insertion sort of the lane values, reversed for descending.
    function automatic logic [255:0] ref_sort(input logic [255:0] d, input logic desc,
                                              input int n, input int w);
        longint unsigned v [16];
        longint unsigned x;
        logic [255:0] r;
        int j;
        for (int i = 0; i < n; i++) v[i] = lane_of(d, i, w);
        for (int i = 1; i < n; i++) begin
            x = v[i];
            j = i;
            while (j > 0 && v[j-1] > x) begin
                v[j] = v[j-1];
                j--;
            end
            v[j] = x;
        end
        r = '0;
        for (int i = 0; i < n; i++) r = r | (256'(desc ? v[n-1-i] : v[i]) << (i * w));
        return r;
    endfunction

    typedef struct {
        logic [255:0] data;
        logic         desc;
        int           cyc;
        int           stl;
    } pend_t;

    pend_t        pend [2][$];
    int           stalls [2];
    logic         hold [2];
    logic [255:0] held [2];
    int           delivered [2];

    task automatic mon(input int k, input int n, input int w, input int s,
                       input logic iv, input logic ir, input logic [255:0] id, input logic desc,
                       input logic ov, input logic ordy, input logic [255:0] od
`ifdef SORT_TAG_EN
                       , input logic [255:0] ot
`endif
                       );
        pend_t e;
        if (!rst_n) begin
            pend[k].delete();
            hold[k] = 1'b0;
            return;
        end
        chk("in_ready_rule", 256'(ir), 256'(!(ov && !ordy)));
        if (hold[k]) begin
            chk("hold_valid", 256'(ov), 256'(1));
            chk("hold_data", od, held[k]);
        end
        if (ov && ordy) begin
            if (pend[k].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output inst=%0d actual=%0h required=none", k, od);
            end else begin
                e = pend[k].pop_front();
                chk("sorted_data", od, ref_sort(e.data, e.desc, n, w));
                chk("latency", 256'(cyc - e.cyc), 256'(s + stalls[k] - e.stl));
`ifdef SORT_TAG_EN
                begin
                    logic [15:0] seen;
                    logic        ok;
                    int          t;
                    int          iw;
                    iw   = $clog2(n);
                    seen = '0;
                    ok   = 1'b1;
                    for (int i = 0; i < n; i++) begin
                        t = int'(lane_of(ot, i, iw));
                        if (seen[t]) ok = 1'b0;
                        seen[t] = 1'b1;
                        if (lane_of(e.data, t, w) != lane_of(od, i, w)) ok = 1'b0;
                    end
                    chk("tag_perm", 256'(ok), 256'(1));
                end
`endif
                delivered[k]++;
            end
        end
        if (iv && ir) begin
            e.data = id;
            e.desc = desc;
            e.cyc  = cyc;
            e.stl  = stalls[k];
            pend[k].push_back(e);
        end
        if (!ir) stalls[k]++;
        hold[k] = ov && !ordy;
        held[k] = od;
    endtask

    always @(negedge clk) begin
`ifdef SORT_TAG_EN
        mon(0, 4, 10, 3, a_iv, a_ir, 256'(a_id), a_desc, a_ov, a_ordy, 256'(a_od), 256'(a_ot));
        mon(1, 16, 16, 10, b_iv, b_ir, b_id, b_desc, b_ov, b_ordy, b_od, 256'(b_ot));
`else
        mon(0, 4, 10, 3, a_iv, a_ir, 256'(a_id), a_desc, a_ov, a_ordy, 256'(a_od));
        mon(1, 16, 16, 10, b_iv, b_ir, b_id, b_desc, b_ov, b_ordy, b_od);
`endif
    end

    function automatic logic [39:0] pk4(input int l0, input int l1, input int l2, input int l3);
        return {10'(l3), 10'(l2), 10'(l1), 10'(l0)};
    endfunction

    function automatic logic [7:0] tg4(input int t0, input int t1, input int t2, input int t3);
        return {2'(t3), 2'(t2), 2'(t1), 2'(t0)};
    endfunction

    typedef struct {
        logic [39:0] data;
        logic        desc;
        logic [39:0] exp;
        logic [7:0]  tag;
    } vec_t;

    localparam int NT = 8;
    vec_t        tbl [NT];
    logic [39:0] sv [6];
    logic        sd [6];
    int          idx;
    int          d0;
    int          sent;
    int          guard;
    logic        narrow;

    initial begin
        tbl[0] = '{pk4(5, 1023, 0, 7),      1'b1, pk4(1023, 7, 5, 0),     tg4(1, 3, 0, 2)};
        tbl[1] = '{pk4(5, 1023, 0, 7),      1'b0, pk4(0, 5, 7, 1023),     tg4(2, 0, 3, 1)};
        tbl[2] = '{pk4(9, 9, 9, 9),         1'b0, pk4(9, 9, 9, 9),        tg4(0, 1, 2, 3)};
        tbl[3] = '{pk4(9, 9, 9, 9),         1'b1, pk4(9, 9, 9, 9),        tg4(0, 1, 2, 3)};
        tbl[4] = '{pk4(0, 1, 2, 3),         1'b0, pk4(0, 1, 2, 3),        tg4(0, 1, 2, 3)};
        tbl[5] = '{pk4(0, 1, 2, 3),         1'b1, pk4(3, 2, 1, 0),        tg4(3, 2, 1, 0)};
        tbl[6] = '{pk4(1023, 0, 512, 511),  1'b0, pk4(0, 511, 512, 1023), tg4(1, 3, 2, 0)};
        tbl[7] = '{pk4(1, 2, 1023, 1022),   1'b1, pk4(1023, 1022, 2, 1),  tg4(2, 3, 1, 0)};

        checks = 0;
        errors = 0;
        for (int k = 0; k < 2; k++) begin
            stalls[k] = 0;
            hold[k] = 1'b0;
            held[k] = '0;
            delivered[k] = 0;
        end
        rst_n = 1'b0;
        a_iv = 1'b0; a_id = '0; a_desc = 1'b0; a_ordy = 1'b1;
        b_iv = 1'b0; b_id = '0; b_desc = 1'b0; b_ordy = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        chk("rst_out_valid", 256'(a_ov), 256'(0));
        chk("rst_busy", 256'(a_busy), 256'(0));
        chk("rst_out_data", 256'(a_od), 256'(0));
        chk("rst_in_ready", 256'(a_ir), 256'(1));
        chk("rst_busy16", 256'(b_busy), 256'(0));
        chk("rst_out_data16", b_od, 256'(0));
`ifdef SORT_TAG_EN
        chk("rst_out_tag", 256'(a_ot), 256'(0));
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", 256'(a_ir), 256'(1));

        // Table vectors streamed back-to-back; each result must appear exactly 3 cycles later.
        for (int i = 0; i < NT + 3; i++) begin
            if (i >= 3) begin
                chk("tbl_valid", 256'(a_ov), 256'(1));
                chk("tbl_data", 256'(a_od), 256'(tbl[i-3].exp));
`ifdef SORT_TAG_EN
                chk("tbl_tag", 256'(a_ot), 256'(tbl[i-3].tag));
`endif
            end else begin
                chk("tbl_latency_idle", 256'(a_ov), 256'(0));
            end
            if (i < NT) begin
                a_iv = 1'b1;
                a_id = tbl[i].data;
                a_desc = tbl[i].desc;
            end else begin
                a_iv = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        a_iv = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Six vectors with the consumer stalled for cycles 4..8.
        for (int i = 0; i < 6; i++) begin
            sv[i] = 40'({$urandom, $urandom});
            sd[i] = 1'($urandom_range(0, 1));
        end
        d0 = delivered[0];
        idx = 0;
        for (int t = 0; t < 40; t++) begin
            a_ordy = !(t >= 4 && t < 9);
            if (idx < 6) begin
                a_iv = 1'b1;
                a_id = sv[idx];
                a_desc = sd[idx];
            end else begin
                a_iv = 1'b0;
            end
            @(negedge clk);
            if (t >= 4 && t < 9) chk("stall_in_ready", 256'(a_ir), 256'(0));
            if (a_iv && a_ir) idx++;
            @(posedge clk);
            #1;
        end
        a_iv = 1'b0;
        a_ordy = 1'b1;
        chk("stall_delivered", 256'(delivered[0] - d0), 256'(6));
        chk("stall_pending", 256'(pend[0].size()), 256'(0));

        // Reset with two vectors in flight.
        d0 = delivered[0];
        a_iv = 1'b1; a_id = pk4(100, 200, 300, 400); a_desc = 1'b0;
        @(posedge clk); #1;
        a_id = pk4(4, 3, 2, 1); a_desc = 1'b1;
        @(posedge clk); #1;
        a_iv = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_busy", 256'(a_busy), 256'(0));
        chk("midrst_out_valid", 256'(a_ov), 256'(0));
        for (int t = 0; t < 8; t++) begin
            @(posedge clk); #1;
            chk("no_stale", 256'(a_ov), 256'(0));
        end
        chk("midrst_delivered", 256'(delivered[0] - d0), 256'(0));

        // Random traffic on the 16-lane instance.
        d0 = delivered[1];
        sent = 0;
        guard = 0;
        while (sent < 1000 && guard < 20000) begin
            b_ordy = ($urandom_range(0, 9) < 7);
            b_iv = ($urandom_range(0, 9) < 8);
            narrow = ($urandom_range(0, 3) == 0);
            for (int l = 0; l < 16; l++)
                b_id[l*16 +: 16] = narrow ? 16'($urandom_range(0, 3)) : 16'($urandom);
            b_desc = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (b_iv && b_ir) sent++;
            @(posedge clk);
            #1;
            guard++;
        end
        b_iv = 1'b0;
        b_ordy = 1'b1;
        chk("rand_sent", 256'(sent), 256'(1000));
        for (int g = 0; g < 100 && pend[1].size() != 0; g++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        chk("rand_drain", 256'(pend[1].size()), 256'(0));
        chk("rand_delivered", 256'(delivered[1] - d0), 256'(1000));
        chk("rand_idle_busy", 256'(b_busy), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sort_net_pipe.md
SORT_NET_PIPE -- requirements
Module: sort_net_pipe

Interface
REQ-001 Parameter WIDTH, default 10: unsigned bit width of each element.
REQ-002 Parameter N, default 4: elements per vector; power of two, 2..16.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  in_data/in_desc hold a vector to sort.
REQ-006 in_ready  output  1  block accepts the vector this cycle.
REQ-007 in_data  input  N*WIDTH  lane i at bits [i*WIDTH +: WIDTH].
REQ-008 in_desc  input  1  1 = descending (lane 0 largest), 0 = ascending (lane 0 smallest).
REQ-009 out_valid  output  1  out_data holds a sorted vector.
REQ-010 out_ready  input  1  consumer accepts the output vector this cycle.
REQ-011 out_data  output  N*WIDTH  sorted vector, same lane packing as in_data.
REQ-012 out_tag  output  N*log2(N)  original input lane index of each output lane; present only with SORT_TAG_EN.
REQ-013 busy  output  1  any pipeline stage holds a valid vector.

Function
REQ-014 Sorting SHALL use a bitonic network of S = log2(N)*(log2(N)+1)/2 comparator layers; S = 3 for N=4, 6 for N=8, 10 for N=16.
REQ-015 Each layer SHALL be followed by one register stage; latency from accepted input to out_valid SHALL be exactly S cycles when out_ready stays high.
REQ-016 Comparison SHALL be unsigned over WIDTH bits, computed with a WIDTH+1-bit difference whose borrow bit selects the swap.
REQ-017 A comparator SHALL swap only when its pair is strictly out of order; equal values SHALL not swap.
REQ-018 in_desc SHALL be captured with the vector, travel with it through every stage, and set the direction of every comparator acting on it; successive vectors may differ in direction.
REQ-019 Input is accepted when in_valid && in_ready; output is consumed when out_valid && out_ready.
REQ-020 in_ready SHALL equal !(out_valid && !out_ready); when it is low, every stage holds its state (global stall).
REQ-021 When not stalled, the pipeline SHALL advance every cycle; bubbles propagate as invalid stages. Throughput is one vector per cycle.
REQ-022 While out_valid && !out_ready, out_data, out_tag and out_valid SHALL hold stable.
REQ-023 busy SHALL be the OR of all stage valid bits.
REQ-024 in_data SHALL be ignored when in_valid is low; invalid stages SHALL not raise out_valid.

Reset
REQ-025 While rst_n is low at a clock edge, all stage valid bits, stored data, direction bits and tags SHALL clear to 0; out_valid=0, out_data=0, out_tag=0, busy=0.
REQ-026 in_ready SHALL be 1 during reset and on the first cycle after it.
REQ-027 Reset asserted mid-operation SHALL discard every in-flight vector; none SHALL appear at the output afterwards.

Configuration
REQ-028 Macro SORT_TAG_EN: when defined, each element SHALL carry a log2(N)-bit tag equal to its input lane index, swapped together with the element, and out_tag SHALL be present.
REQ-029 Without SORT_TAG_EN, out_tag and all tag registers SHALL be absent; data and timing SHALL be identical.

Structure
REQ-030 A shared package sort_net_pkg SHALL hold the layer-count function, index-width function and the lane pair/direction tables per layer.
REQ-031 One sub-module, cas_cell (parametrised WIDTH, optional tag, dir input), SHALL implement a single comparator; layers SHALL be generated from it.

Verification (N=4, WIDTH=10 unless noted)
REQ-032 in_data={5,1023,0,7}, in_desc=1, out_ready=1 -> after 3 cycles out_data={1023,7,5,0}, out_tag={1,3,0,2}.
REQ-033 Same vector with in_desc=0 on the next cycle -> the following cycle out_data={0,5,7,1023}; back-to-back output, no bubble.
REQ-034 Stream 6 vectors with out_ready held low from cycle 4 for 5 cycles -> in_ready=0 while stalled, output held stable, all 6 delivered in order with none lost or duplicated.
REQ-035 in_data={9,9,9,9}, in_desc=0 -> out_data={9,9,9,9}, out_tag={0,1,2,3}.
REQ-036 rst_n low for 1 cycle with 2 vectors in flight -> busy=0 and out_valid=0 next cycle, and no stale vector emerges afterwards.
REQ-037 N=16, WIDTH=16: 1000 random vectors with random direction and random out_ready -> outputs match a reference sort, latency 10 when unstalled.
